// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with a single-outstanding load/store front end.
// Generates byte lanes, checks alignment/range and returns extended load data over a valid/ready response.
module data_mem_lsu #(
   parameter int          DEPTH     = 1024,
   parameter int          READ_LAT  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        uns_q, uns_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] word2_q, word2_d;

   logic        accept;
   logic        req_err;
   logic [31:0] addr_off;
   logic [3:0]  lane_mask;
   logic [31:0] wdata_rep;
   logic [31:0] rd_word;
   logic [31:0] src_word;
   logic [31:0] shifted;
   logic [31:0] ext_data;
   logic [AW-1:0] word_idx;

   assign req_ready = (state_q == S_IDLE) & rst_n;
   assign accept    = req_valid & req_ready;
   assign word_idx  = req_addr[AW+1:2];

   always_comb begin
      addr_off = req_addr - BASE_ADDR;
      req_err  = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
               | (req_addr < BASE_ADDR)
               | ({1'b0, addr_off} >= SPAN);
   end

   always_comb begin
      lane_mask = 4'b1111;
      wdata_rep = req_wdata;
      case (req_size)
         2'b00: begin
            lane_mask = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            lane_mask = 4'b0011 << req_addr[1:0];
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // One byte-wide array per lane so each lane gets its own write enable.
   for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (accept && !req_err) begin
            if (req_we) begin
               if (lane_mask[gi]) begin
                  mem[word_idx] <= wdata_rep[8*gi +: 8];
               end
            end else begin
               rd_q <= mem[word_idx];
            end
         end
      end

      assign rd_word[8*gi +: 8] = rd_q;
   end

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      off_d   = off_q;
      uns_d   = uns_q;
      we_d    = we_q;
      err_d   = err_q;
      word2_d = word2_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               size_d = req_size;
               off_d  = req_addr[1:0];
               uns_d  = req_unsigned;
               we_d   = req_we;
               err_d  = req_err;
               if ((READ_LAT == 2) && !req_we && !req_err) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_RD: begin
            word2_d = rd_word;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         word2_q <= 32'h0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         err_q   <= err_d;
         word2_q <= word2_d;
      end
   end

   // Read flops only change on an accepted load, so the response stays stable under backpressure.
   always_comb begin
      src_word = (READ_LAT == 2) ? word2_q : rd_word;
      shifted  = src_word >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ext_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext_data = src_word;
      endcase
      rsp_valid = (state_q == S_RESP);
      rsp_err   = rsp_valid & err_q;
      rsp_rdata = (rsp_valid && !we_q && !err_q) ? ext_data : 32'h0;
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Drives shared random and directed traffic into READ_LAT=1 and READ_LAT=2 instances and
// compares both against a byte-array reference memory.
module tb_data_mem_lsu;

   localparam int DEPTH     = 64;
   localparam int MEM_BYTES = DEPTH * 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_rdata1;
   logic        req_ready2, rsp_valid2, rsp_err2;
   logic [31:0] rsp_rdata2;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model_mem [MEM_BYTES];

   data_mem_lsu #(.DEPTH(DEPTH), .READ_LAT(1), .BASE_ADDR(32'h0)) u_dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   data_mem_lsu #(.DEPTH(DEPTH), .READ_LAT(2), .BASE_ADDR(32'h0)) u_dut_lat2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: little-endian byte memory, natural alignment, range [0, MEM_BYTES).
   task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic exp_err, output logic [31:0] exp_rdata);
      int nb;
      int a;
      logic [31:0] val;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      exp_err = (size == 2'd3) || ((int'(addr[1:0]) % nb) != 0) || (addr >= 32'(MEM_BYTES));
      exp_rdata = 32'h0;
      if (!exp_err) begin
         a = int'(addr);
         if (we) begin
            for (int k = 0; k < nb; k++) model_mem[a + k] = wdata[8*k +: 8];
         end else begin
            val = 32'h0;
            for (int k = 0; k < nb; k++) val = val | (32'(model_mem[a + k]) << (8 * k));
            if (!uns && nb < 4 && val[8*nb - 1]) val = val | (32'hFFFF_FFFF << (8 * nb));
            exp_rdata = val;
         end
      end
   endtask

   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] got);
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic        early2;
      model_op(we, size, uns, addr, wdata, exp_err, exp_rdata);
      early2 = we || exp_err;

      @(negedge clk);
      chk("req_ready1_idle", 32'(req_ready1), 32'd1);
      chk("req_ready2_idle", 32'(req_ready2), 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
      req_addr  = $urandom;
      chk("lat1_valid_after_e0", 32'(rsp_valid1), 32'd1);
      chk("lat2_valid_after_e0", 32'(rsp_valid2), 32'(early2));
      if (!early2) begin
         @(posedge clk);
         #1;
         chk("lat2_valid_after_e1", 32'(rsp_valid2), 32'd1);
      end
      chk("rdata1", rsp_rdata1, exp_rdata);
      chk("rdata2", rsp_rdata2, exp_rdata);
      chk("err1", 32'(rsp_err1), 32'(exp_err));
      chk("err2", 32'(rsp_err2), 32'(exp_err));
      got = rsp_rdata1;

      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid1", 32'(rsp_valid1), 32'd1);
         chk("hold_valid2", 32'(rsp_valid2), 32'd1);
         chk("hold_rdata1", rsp_rdata1, exp_rdata);
         chk("hold_rdata2", rsp_rdata2, exp_rdata);
         chk("hold_ready1", 32'(req_ready1), 32'd0);
         chk("hold_ready2", 32'(req_ready2), 32'd0);
      end

      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("done_valid1", 32'(rsp_valid1), 32'd0);
      chk("done_valid2", 32'(rsp_valid2), 32'd0);
      chk("done_rdata1", rsp_rdata1, 32'd0);
      chk("done_err2", 32'(rsp_err2), 32'd0);
      chk("done_ready1", 32'(req_ready1), 32'd1);
      $display("op we=%0d sz=%0d u=%0d addr=%08h wdata=%08h hold=%0d -> rdata=%08h err=%0d",
               we, size, uns, addr, wdata, hold, got, rsp_err1 | exp_err);
   endtask

   initial begin
      logic [31:0] r;
      logic        we;
      logic [1:0]  sz;
      logic [31:0] ad;

      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      rsp_ready    = 1'b0;

      // Reset held with traffic on the request side.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 32'($urandom_range(0, 63)) << 2;
         req_wdata = $urandom;
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rst_ready1", 32'(req_ready1), 32'd0);
         chk("rst_ready2", 32'(req_ready2), 32'd0);
         chk("rst_valid1", 32'(rsp_valid1), 32'd0);
         chk("rst_valid2", 32'(rsp_valid2), 32'd0);
         chk("rst_rdata1", rsp_rdata1, 32'd0);
         chk("rst_rdata2", rsp_rdata2, 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      rst_n     = 1'b1;
      #1;
      chk("rel_ready1", 32'(req_ready1), 32'd1);
      chk("rel_ready2", 32'(req_ready2), 32'd1);

      // Fill every word so all later loads have defined contents.
      for (int w = 0; w < DEPTH; w++) do_op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, r);

      // Store then sub-word loads with both extensions.
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, r);
      do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, r);  chk("t2_lb",  r, 32'hFFFFFFDE);
      do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, r);  chk("t2_lbu", r, 32'h000000DE);
      do_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, r);  chk("t2_lh",  r, 32'hFFFFBEEF);
      do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, r);  chk("t2_lhu", r, 32'h0000DEAD);

      // Partial stores merge into the existing word.
      do_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, r);
      do_op(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF55, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r);  chk("t3_sb_merge", r, 32'h11225544);
      do_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234AAAA, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r);  chk("t3_sh_merge", r, 32'hAAAA5544);

      // Error cases, including stores that must not reach the array.
      do_op(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, r);
      do_op(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES), 32'h0, 0, r);
      do_op(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES), 32'h0BADF00D, 0, r);
      do_op(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF, 0, r);
      do_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h01020304, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0, r);
      do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r);  chk("t4_unchanged", r, 32'hAAAA5544);
      do_op(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'h0, 0, r);

      // Backpressure on the response channel.
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r);  chk("t5_bp_data", r, 32'hDEADBEEF);

      // Reset pulse while the READ_LAT=2 instance sits in its extra read cycle.
      do_op(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 0, r);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd2;
      req_addr  = 32'h30;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("t6_lat1_resp", 32'(rsp_valid1), 32'd1);
      chk("t6_lat2_rd",   32'(rsp_valid2), 32'd0);
      #1;
      rst_n = 1'b0;
      #2;
      chk("t6_rst_valid1", 32'(rsp_valid1), 32'd0);
      chk("t6_rst_ready2", 32'(req_ready2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t6_no_rsp1", 32'(rsp_valid1), 32'd0);
         chk("t6_no_rsp2", 32'(rsp_valid2), 32'd0);
      end
      do_op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, r);  chk("t6_intact", r, 32'hCAFEF00D);

      // Randomised mix, including some out-of-range and misaligned accesses.
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         ad = 32'($urandom_range(0, MEM_BYTES + 15));
         if ($urandom_range(0, 15) == 0) ad = $urandom;
         do_op(we, sz, 1'($urandom_range(0, 1)), ad, $urandom, int'($urandom_range(0, 3)), r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
